// File: rtl/ircam_pkg.sv
// Shared types and defaults for the thermal-camera ping-pong frame buffer.
package ircam_pkg;

  localparam int FRAME_PIX_DEF = 768;
  localparam int ADDR_W_DEF    = 10;

  typedef logic bank_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } wr_state_t;

endpackage

// File: rtl/ircam_bank_mgr.sv
// Bank ownership: ready frame, reader claim/release, overwrite drops, and the
// writer's target bank for the next frame.
module ircam_bank_mgr
  import ircam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sof_pick,
  input  logic       done_p1,
  input  logic       done_bank,
  input  logic       rd_start,
  input  logic       rd_done,
  output logic       frm_rdy,
  output logic       frm_bank,
  output logic       rd_busy,
  output logic       rd_bank,
  output logic [7:0] drop_cnt,
  output logic       tgt_bank
);

  bank_t last_bank;
  logic  busy_rel;
  logic  claim;
  logic  busy_nx;
  bank_t rdbank_nx;
  logic  rdy_eff;
  bank_t fbank_eff;
  bank_t last_eff;
  logic  drop;

  // Order within one edge: release, then claim, then frame completion, then
  // the writer's pick, so the pick always sees the reader's next-cycle bank.
  always_comb begin
    busy_rel  = rd_busy & ~rd_done;
    claim     = rd_start & frm_rdy & ~busy_rel;
    busy_nx   = busy_rel | claim;
    rdbank_nx = claim ? frm_bank : rd_bank;
    rdy_eff   = (frm_rdy & ~claim) | done_p1;
    fbank_eff = done_p1 ? done_bank : frm_bank;
    last_eff  = done_p1 ? done_bank : last_bank;
    if (busy_nx)
      tgt_bank = ~rdbank_nx;
    else if (rdy_eff)
      tgt_bank = ~fbank_eff;
    else
      tgt_bank = ~last_eff;
    drop = sof_pick & rdy_eff & (tgt_bank == fbank_eff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_rdy   <= 1'b0;
      frm_bank  <= 1'b0;
      rd_busy   <= 1'b0;
      rd_bank   <= 1'b0;
      last_bank <= 1'b1;
      drop_cnt  <= 8'd0;
    end else begin
      frm_rdy   <= rdy_eff & ~drop;
      frm_bank  <= fbank_eff;
      rd_busy   <= busy_nx;
      rd_bank   <= rdbank_nx;
      last_bank <= last_eff;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/ircam_frame_ctrl.sv
// Ping-pong frame-buffer controller: writes camera frames into alternating
// banks and hands completed frames to one reader via claim/release.
module ircam_frame_ctrl
  import ircam_pkg::*;
#(
  parameter int FRAME_PIX = FRAME_PIX_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_sof,
  input  logic              cam_vald,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frm_rdy,
  output logic              frm_bank,
  input  logic              rd_start,
  input  logic              rd_done,
  output logic              rd_busy,
  output logic              rd_bank,
  output logic [15:0]       frm_cnt,
  output logic [7:0]        drop_cnt,
  output logic              err_short
);

  wr_state_t         state, state_nx;
  logic [ADDR_W-1:0] pix_cnt, pix_nx;
  bank_t             cur_bank, bank_nx;
  logic              sof_pick;
  logic              fire;
  logic              last_wr;
  logic              err_nx;
  logic              done_p1;
  logic              tgt_bank;

  ircam_bank_mgr u_bank_mgr (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof_pick  (sof_pick),
    .done_p1   (done_p1),
    .done_bank (cur_bank),
    .rd_start  (rd_start),
    .rd_done   (rd_done),
    .frm_rdy   (frm_rdy),
    .frm_bank  (frm_bank),
    .rd_busy   (rd_busy),
    .rd_bank   (rd_bank),
    .drop_cnt  (drop_cnt),
    .tgt_bank  (tgt_bank)
  );

  always_comb begin
    state_nx = state;
    pix_nx   = pix_cnt;
    bank_nx  = cur_bank;
    sof_pick = 1'b0;
    fire     = 1'b0;
    last_wr  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      W_IDLE: begin
        if (cam_sof) begin
          sof_pick = 1'b1;
          bank_nx  = tgt_bank;
          pix_nx   = '0;
          state_nx = W_FILL;
        end
      end
      W_FILL: begin
        // A mid-frame header restarts the same bank; a coincident pixel is dropped.
        if (cam_sof) begin
          err_nx = 1'b1;
          pix_nx = '0;
        end else if (cam_vald) begin
          fire   = 1'b1;
          pix_nx = pix_cnt + ADDR_W'(1);
          if (pix_cnt == ADDR_W'(FRAME_PIX - 1)) begin
            last_wr  = 1'b1;
            pix_nx   = '0;
            state_nx = W_IDLE;
          end
        end
      end
      default: state_nx = W_IDLE;
    endcase
  end

  // Write stage p0 -> p1; completion is published one cycle after the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= W_IDLE;
      pix_cnt   <= '0;
      cur_bank  <= 1'b0;
      wr_en     <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'd0;
      done_p1   <= 1'b0;
      frm_cnt   <= 16'd0;
      err_short <= 1'b0;
    end else begin
      state     <= state_nx;
      pix_cnt   <= pix_nx;
      cur_bank  <= bank_nx;
      wr_en     <= fire;
      if (fire) begin
        wr_bank <= cur_bank;
        wr_addr <= pix_cnt;
        wr_data <= cam_data;
      end
      done_p1   <= last_wr;
      frm_cnt   <= frm_cnt + {15'd0, done_p1};
      err_short <= err_nx;
    end
  end

endmodule

// File: tb/tb_ircam_frame_ctrl.sv
// Directed bench for ircam_frame_ctrl with a write scoreboard.
module tb_ircam_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cam_sof, cam_vald;
  logic [7:0] cam_data;
  logic       wr_en, wr_bank;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frm_rdy, frm_bank;
  logic       rd_start, rd_done;
  logic       rd_busy, rd_bank;
  logic [15:0] frm_cnt;
  logic [7:0] drop_cnt;
  logic       err_short;

  typedef struct packed {
    logic       b;
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  ircam_frame_ctrl #(.FRAME_PIX(768), .ADDR_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cam_sof   (cam_sof),
    .cam_vald  (cam_vald),
    .cam_data  (cam_data),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frm_rdy   (frm_rdy),
    .frm_bank  (frm_bank),
    .rd_start  (rd_start),
    .rd_done   (rd_done),
    .rd_busy   (rd_busy),
    .rd_bank   (rd_bank),
    .frm_cnt   (frm_cnt),
    .drop_cnt  (drop_cnt),
    .err_short (err_short)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every registered write must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_write observed=%0h expected=none", {wr_bank, wr_addr, wr_data});
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        assert ({wr_bank, wr_addr, wr_data} === e) else begin
          n_err++;
          $error("FAIL wr_stream observed=%0h expected=%0h", {wr_bank, wr_addr, wr_data}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    cam_sof = 1'b1;
    tick();
    cam_sof = 1'b0;
  endtask

  task automatic pixels(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      cam_vald = 1'b1;
      cam_data = 8'(i);
      exp_q.push_back({b, 10'(i), 8'(i)});
      tick();
    end
    cam_vald = 1'b0;
  endtask

  task automatic finish_frame(input logic b, input int cnt);
    tick();
    chk("frm_rdy_after_frame", {31'd0, frm_rdy}, 32'd1);
    chk("frm_bank_after_frame", {31'd0, frm_bank}, {31'd0, b});
    chk("frm_cnt_after_frame", {16'd0, frm_cnt}, 32'(cnt));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, {20'd0, wr_en, wr_bank, wr_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, wr_data}, 32'd0);
    chk({tag, "_frm"}, {28'd0, frm_rdy, frm_bank, rd_busy, rd_bank}, 32'd0);
    chk({tag, "_frm_cnt"}, {16'd0, frm_cnt}, 32'd0);
    chk({tag, "_drop_err"}, {23'd0, drop_cnt, err_short}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cam_sof = 1'b0; cam_vald = 1'b0; cam_data = 8'd0;
    rd_start = 1'b0; rd_done = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Idle pixels, a claim with nothing ready, and a stray release are all ignored.
    cam_vald = 1'b1; cam_data = 8'h33;
    rd_start = 1'b1; tick();
    rd_start = 1'b0; rd_done = 1'b1; tick();
    rd_done = 1'b0; cam_vald = 1'b0; tick();
    chk("idle_ignored", {29'd0, wr_en, rd_busy, frm_rdy}, 32'd0);

    // First frame lands in bank 0.
    sof_pulse();
    pixels(1'b0, 768);
    chk("last_wr_en", {31'd0, wr_en}, 32'd1);
    chk("frm_rdy_not_yet", {31'd0, frm_rdy}, 32'd0);
    finish_frame(1'b0, 1);

    // Reader claims bank 0.
    rd_start = 1'b1; tick(); rd_start = 1'b0;
    chk("claim0", {29'd0, rd_busy, rd_bank, frm_rdy}, {29'd0, 1'b1, 1'b0, 1'b0});

    // Two frames into bank 1; the second overwrites the unread first.
    sof_pulse();
    pixels(1'b1, 768);
    finish_frame(1'b1, 2);
    sof_pulse();
    chk("overwrite_rdy", {31'd0, frm_rdy}, 32'd0);
    chk("overwrite_drop", {24'd0, drop_cnt}, 32'd1);
    pixels(1'b1, 768);
    finish_frame(1'b1, 3);

    // Release, then short frame on bank 0 restarted by a header colliding with a pixel.
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    chk("release", {31'd0, rd_busy}, 32'd0);
    sof_pulse();
    pixels(1'b0, 100);
    cam_sof = 1'b1; cam_vald = 1'b1; cam_data = 8'hEE;
    tick();
    cam_sof = 1'b0; cam_vald = 1'b0;
    chk("err_short_pulse", {30'd0, err_short, wr_en}, 32'd2);
    tick();
    chk("err_short_clear", {31'd0, err_short}, 32'd0);
    chk("short_frm_cnt", {16'd0, frm_cnt}, 32'd3);
    pixels(1'b0, 768);
    finish_frame(1'b0, 4);
    chk("short_drop", {24'd0, drop_cnt}, 32'd1);

    // Claim and header in the same cycle: writer moves to bank 1, no drop.
    rd_start = 1'b1; cam_sof = 1'b1; tick();
    rd_start = 1'b0; cam_sof = 1'b0;
    chk("claim_sof", {29'd0, rd_busy, rd_bank, frm_rdy}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("claim_sof_drop", {24'd0, drop_cnt}, 32'd1);
    pixels(1'b1, 768);
    finish_frame(1'b1, 5);

    // Release and claim together: reader hops to bank 1.
    rd_done = 1'b1; rd_start = 1'b1; tick();
    rd_done = 1'b0; rd_start = 1'b0;
    chk("swap", {29'd0, rd_busy, rd_bank, frm_rdy}, {29'd0, 1'b1, 1'b1, 1'b0});

    // Reset 400 pixels into a bank-0 frame.
    sof_pulse();
    pixels(1'b0, 400);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    sof_pulse();
    pixels(1'b0, 768);
    finish_frame(1'b0, 1);
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ircam_frame_ctrl.md
# ircam_frame_ctrl

Ping-pong frame-buffer controller between the thermal-camera pixel stream and the NICE/PE consumer. Takes the 8-bit normalised pixel stream plus a start-of-frame pulse, places each 32x24 frame into one of two buffer banks, and hands completed frames to a single reader through a claim/release handshake. It also decides which bank the camera writes and which bank the reader owns, so neither side ever touches the other's bank.

## Interface
- FRAME_PIX, 768, pixels per frame (32x24)
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= FRAME_PIX
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cam_sof  in  1  one-cycle start-of-frame pulse (0x5A5A header detected)
- cam_vald  in  1  pixel strobe
- cam_data  in  8  pixel value
- wr_en  out  1  bank write enable
- wr_bank  out  1  bank being written
- wr_addr  out  ADDR_W  pixel address within bank
- wr_data  out  8  pixel value to write
- frm_rdy  out  1  a complete, unclaimed frame is available
- frm_bank  out  1  bank holding that frame
- rd_start  in  1  reader claims frm_bank (pulse)
- rd_done  in  1  reader releases its bank (pulse)
- rd_busy  out  1  reader currently owns rd_bank
- rd_bank  out  1  bank owned by reader
- frm_cnt  out  16  completed frames, wraps at 65535 -> 0
- drop_cnt  out  8  unread frames overwritten, saturates at 255
- err_short  out  1  one-cycle pulse: cam_sof arrived mid-frame

## Operation
- Writer FSM has two states. W_IDLE waits for cam_sof. W_FILL writes pixels. cam_vald in W_IDLE is ignored.
- On cam_sof, the writer picks the target bank and clears the pixel counter, then enters W_FILL.
- Target-bank rule, evaluated on the reader's post-update ownership:
  - if the reader will own bank X next cycle, target ~X;
  - else if a ready frame remains, target ~frm_bank;
  - else target ~last_written_bank.
- Overwrite: if the target equals frm_bank while frm_rdy=1 (reader owns the other bank), clear frm_rdy at the same edge and increment drop_cnt.
- In W_FILL, each cam_vald registers wr_en=1, wr_addr=pix_cnt, wr_data=cam_data, wr_bank=target, then increments pix_cnt.
- When the write with pix_cnt=FRAME_PIX-1 is issued:
  - go to W_IDLE;
  - one cycle later set frm_rdy=1 and frm_bank=target, increment frm_cnt, and set last_written_bank=target.
- cam_sof while in W_FILL: pulse err_short, discard the partial frame, restart at address 0 on the same bank. frm_cnt is unchanged.
- cam_sof and cam_vald in the same cycle: cam_sof wins and the pixel is dropped.
- rd_start is accepted only when frm_rdy=1 and rd_busy=0. On acceptance: rd_busy<=1, rd_bank<=frm_bank, frm_rdy<=0. Otherwise rd_start is ignored.
- rd_done with rd_busy=1 clears rd_busy. rd_done with rd_busy=0 is ignored.
- rd_done and rd_start in the same cycle: apply the release first, then the claim. rd_busy stays 1 and rd_bank switches.
- rd_start accepted in the same cycle as cam_sof: the claim happens first, the writer targets the other bank, and there is no drop.
- Frame completion in the same cycle as rd_start: the claim uses the pre-edge frm_rdy/frm_bank. The newly completed frame becomes ready after the claim.

## Timing
- All outputs are registered.
- wr_* follows cam_vald by 1 cycle.
- frm_rdy rises 1 cycle after the final wr_en, so the frame is fully written before the reader can claim it.
- frm_rdy falls on the edge that accepts rd_start, or on the edge of the overwriting cam_sof.
- Reset (async assert, sync deassert handled upstream):
  - all outputs 0;
  - FSM in W_IDLE, pix_cnt=0;
  - last_written_bank=1, so the first frame goes to bank 0.
- Reset mid-frame drops the partial frame and any ready or claimed state. The reader must re-handshake after reset.

## Structure
- Shared package ircam_pkg: FRAME_PIX default, writer state enum (W_IDLE, W_FILL), bank index type.
- One sub-module, ircam_bank_mgr, holds frm_rdy/frm_bank, rd_busy/rd_bank, last_written_bank and drop_cnt. It applies the claim/release/overwrite priority and returns the writer target bank on cam_sof.
- The top level holds the writer FSM, pix_cnt, the wr_* registers and frm_cnt.

## Test plan
- Reset, then cam_sof plus 768 pixels (values 0..255 repeating): wr_addr 0..767 on bank 0. frm_rdy=1 and frm_bank=0 one cycle after the last wr_en. frm_cnt=1.
- Reader claims bank 0 (rd_busy=1, rd_bank=0). Two full frames follow: the first goes to bank 1 and becomes ready; the second cam_sof clears frm_rdy, rewrites bank 1, and drop_cnt=1.
- cam_sof after 100 pixels: err_short pulses once, wr_addr restarts at 0 on the same bank, frm_cnt unchanged. A subsequent full frame sets frm_rdy.
- frm_rdy=1 on bank 0 with rd_start and cam_sof in the same cycle: rd_bank=0, the writer targets bank 1, drop_cnt unchanged.
- rd_busy=1 on bank 0, frm_rdy on bank 1, rd_done and rd_start in the same cycle: rd_busy stays 1, rd_bank=1, frm_rdy=0.
- rst_n asserted at pixel 400: all outputs 0 immediately. The next frame writes bank 0 from address 0.
